vga_fb_arbiter: RTL

- Shares one single-port, 1-cycle-read-latency framebuffer memory between two masters:
  - the VGA line prefetcher, which copies one scan line into the display line buffer during horizontal blanking;
  - the CPU, which reads and writes through a req/ack port.
- Sits between the VGA timing generator, the framebuffer RAM, the line buffer and the CPU bus bridge.
- Display fetch has priority; the CPU is stalled during a fetch unless the slot feature is compiled in.

---
 rtl/vga_fb_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a 1-cycle-latency framebuffer RAM between the VGA line prefetcher and the CPU port (VGA_FB_CPU_SLOT_EN opens CPU slots inside a fetch).
// Latency: fetch word i issued i+1 cycles after line_start is accepted, line-buffer write one cycle later; CPU ack 2 cycles after acceptance.
// Backpressure: cpu_req is held until cpu_ack; line_start is never stalled, overruns set fetch_err and one line may pend behind a CPU access.
module vga_fb_arbiter #(
    parameter int WORDS_PER_LINE = 40,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int LINE_W         = 10
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [LINE_W-1:0] line_num,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err,
    input  logic              err_clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [5:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata
);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CPU_ISSUE, CPU_ACK} state_t;

    localparam logic [5:0]        LAST_IDX = 6'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] WPL      = ADDR_W'(WORDS_PER_LINE);

    state_t              state_q, state_d;
    logic [5:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                pend_q, pend_d;
    logic [LINE_W-1:0]   pend_num_q, pend_num_d;
    logic [LINE_W-1:0]   start_num;
    logic                slot_q, slot_d;
    logic                err_q, err_set;
    logic                fetch_issue, cpu_issue;
    // Tag pipeline: which master owns mem_rdata in the current cycle.
    logic                rd_fetch_q;
    logic [5:0]          rd_idx_q;
    logic                ack_q;
    logic                cpu_rd_q;

    assign start_num = pend_q ? pend_num_q : line_num;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        pend_d      = pend_q;
        pend_num_d  = pend_num_q;
        slot_d      = 1'b0;
        err_set     = 1'b0;
        fetch_issue = 1'b0;
        cpu_issue   = 1'b0;
        case (state_q)
            IDLE, CPU_ACK: begin
                if (pend_q || line_start) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    base_d  = ADDR_W'(start_num) * WPL;
                    if (pend_q && line_start) begin
                        err_set = 1'b1;
                    end
                end else if (state_q == IDLE && cpu_req) begin
                    state_d = CPU_ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (line_start) begin
                    err_set = 1'b1;
                end
                if (slot_q) begin
                    cpu_issue = 1'b1;
                end else begin
                    fetch_issue = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + 6'd1;
`ifdef VGA_FB_CPU_SLOT_EN
                        slot_d = (idx_q[2:0] == 3'b111) && cpu_req;
`endif
                    end
                end
            end
            DRAIN: begin
                if (line_start) begin
                    err_set = 1'b1;
                end
                state_d = IDLE;
            end
            CPU_ISSUE: begin
                cpu_issue = 1'b1;
                state_d   = CPU_ACK;
                if (line_start) begin
                    if (pend_q) begin
                        err_set = 1'b1;
                    end else begin
                        pend_d     = 1'b1;
                        pend_num_d = line_num;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            pend_q     <= 1'b0;
            pend_num_q <= '0;
            slot_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_fetch_q <= 1'b0;
            rd_idx_q   <= '0;
            ack_q      <= 1'b0;
            cpu_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            pend_q     <= pend_d;
            pend_num_q <= pend_num_d;
            slot_q     <= slot_d;
            rd_fetch_q <= fetch_issue;
            rd_idx_q   <= idx_q;
            ack_q      <= cpu_issue;
            cpu_rd_q   <= cpu_issue && !cpu_we;
            // A new overrun outranks a simultaneous clear.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_en     = fetch_issue || cpu_issue;
        mem_we     = cpu_issue && cpu_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (cpu_issue) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (fetch_issue) begin
            mem_addr  = base_q + ADDR_W'(idx_q);
        end
        lb_we      = rd_fetch_q;
        lb_addr    = rd_fetch_q ? rd_idx_q : 6'd0;
        lb_wdata   = rd_fetch_q ? mem_rdata : '0;
        fetch_done = rd_fetch_q && (rd_idx_q == LAST_IDX);
        fetch_busy = (state_q == FETCH) || (state_q == DRAIN);
        fetch_err  = err_q;
        cpu_ack    = ack_q;
        cpu_rdata  = cpu_rd_q ? mem_rdata : '0;
    end

endmodule
